// File: rtl/piso_uart_tx.sv
// Splits a parallel word into BYTE_W-wide bytes, LSB byte first, and writes them
// one per cycle into a downstream TX FIFO. The FIFO full flag stalls the transfer.
module piso_uart_tx #(
  parameter int NUM_BYTES = 4,
  parameter int BYTE_W    = 8
) (
  input  logic                        Clk,
  input  logic                        Rst,
  input  logic                        i_start,
  input  logic [NUM_BYTES*BYTE_W-1:0] i_word,
  input  logic                        no_write,
  output logic                        w_flag,
  output logic [BYTE_W-1:0]           Written_value,
  output logic                        o_busy,
  output logic                        o_done
);

  // state | meaning
  // IDLE  | waiting for i_start; the word is captured on the accepting edge
  // SEND  | one byte per cycle to the FIFO, held while no_write is high
  // DONE  | single-cycle o_done pulse, then back to IDLE

  localparam int WORD_W = NUM_BYTES * BYTE_W;
  localparam int CNT_W  = (NUM_BYTES > 1) ? $clog2(NUM_BYTES) : 1;
  localparam logic [CNT_W-1:0] LAST_BYTE = CNT_W'(NUM_BYTES - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t              state;
  state_t              state_nxt;
  logic [WORD_W-1:0]   shift_q;
  logic [CNT_W-1:0]    cnt_q;
  logic                last_byte;

  assign last_byte     = (cnt_q == LAST_BYTE);
  assign Written_value = shift_q[BYTE_W-1:0];

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    w_flag    = 1'b0;
    o_busy    = 1'b0;
    o_done    = 1'b0;
    case (state)
      IDLE: begin
        if (i_start) state_nxt = SEND;
      end
      SEND: begin
        o_busy = 1'b1;
        w_flag = !no_write;
        if (!no_write && last_byte) state_nxt = DONE;
      end
      DONE: begin
        o_done    = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // The counter stops at the last index so it never wraps inside a word.
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      shift_q <= '0;
      cnt_q   <= '0;
    end else if (state == IDLE && i_start) begin
      shift_q <= i_word;
      cnt_q   <= '0;
    end else if (w_flag) begin
      shift_q <= shift_q >> BYTE_W;
      if (!last_byte) cnt_q <= cnt_q + 1'b1;
    end
  end

endmodule
